bus_cycle_ctrl: RTL
===================

# bus_cycle_ctrl

Synchronous bus-cycle controller for the Simple008 68008 glue CPLD. It replaces the purely combinational DTACK with per-region programmable wait states. It also adds a bus-error watchdog that asserts BERR_n when an AS_n cycle receives no chip select and no autovector. It sits between the address decoder (chip selects, VPA_n) and the CPU's DTACK_n/BERR_n pins.

## Interface
- ROM_WAIT, default 2: wait cycles (CLK edges) before DTACK for ROM (0..15).
- RAM_WAIT, default 0: wait cycles for SRAM.
- DUA_WAIT, default 1: wait cycles for DUART access and DUART IACK.
- EXP_WAIT, default 3: wait cycles for expansion.
- BERR_TIMEOUT, default 64: CLK edges from AS_n sampled low to BERR_n (16..255). Every *_WAIT value must be < BERR_TIMEOUT.
- Reset: one clock; reset is synchronous and active-high.
- CLK  in  1  system clock (CPU clock).
- RST  in  1  synchronous active-high reset.
- AS_n  in  1  CPU address strobe. Already synchronous to CLK; no synchronizer is in this block.
- ROMSEL_n, RAMSEL_n, DUASEL_n, EXPSEL_n  in  1 each  decoded selects, active low.
- DUAIACK_n  in  1  DUART interrupt-acknowledge select, active low.
- VPA_n  in  1  autovector request from the IACK logic, active low.
- DTACK_n  out  1  registered data-transfer acknowledge.
- BERR_n  out  1  registered bus error.
- BUSY  out  1  high while state is not IDLE.
- BERR_CNT  out  8  saturating count of bus errors since reset.

## Operation
- States: IDLE, PEND, WAIT, ACK, VPA, BERR.
- Select priority, latched on entry to WAIT/ACK: ROMSEL_n > RAMSEL_n > DUASEL_n = DUAIACK_n (DUA region) > EXPSEL_n. The latched region's wait value W loads the 4-bit counter `wcnt`.
- IDLE, AS_n=0:
  - select active, W=0: go to ACK; DTACK_n<=0.
  - select active, W>0: go to WAIT; wcnt<=W.
  - VPA_n=0 and no select: go to VPA.
  - otherwise: go to PEND; tcnt<=1.
- PEND (AS_n=0): the same select/VPA checks as IDLE are evaluated first. Else, if tcnt==BERR_TIMEOUT-1, go to BERR with BERR_n<=0 and BERR_CNT incremented (saturating at 255). Else tcnt++.
- WAIT: wcnt decrements each edge. At the edge where wcnt==1, go to ACK with DTACK_n<=0. Select changes during WAIT are ignored.
- ACK, VPA and BERR: hold until AS_n is sampled high, then go to IDLE with DTACK_n<=1 and BERR_n<=1.
- AS_n sampled high in PEND or WAIT (aborted cycle): go to IDLE; no DTACK, no BERR.
- In VPA, DTACK_n and BERR_n stay high. DTACK and VPA are never asserted together.
- If a select and VPA_n are both low, the select wins (DTACK path).
- tcnt is 8-bit and clears on every return to IDLE.
- RST at any time, including mid-cycle: state IDLE, DTACK_n=1, BERR_n=1, BUSY=0, BERR_CNT=0, wcnt=0, tcnt=0.

## Timing
- Let edge k be the first CLK edge sampling AS_n=0 with a select active.
- DTACK_n is low after edge k+W (W=0: after edge k) and stays low until the edge after AS_n is sampled high.
- With no select, BERR_n is low after edge k+BERR_TIMEOUT-1, counting the first AS_n-low edge as edge k.
- If a select first appears in PEND at edge j, DTACK_n is low after edge j+W.
- Back-to-back cycles: a return to IDLE takes one edge, and a new AS_n low may be accepted on the following edge.
- All outputs are registered; there is no combinational path from inputs to DTACK_n or BERR_n.

## Structure
- Shared package simple008_pkg holds:
  - the state enum (6 states, 3 bits) and the region enum (ROM, RAM, DUA, EXP);
  - the WAIT_W=4 and TCNT_W=8 width constants.
- Single module; no sub-module. The wait counter and timeout counter are inline registers.

## Test plan
- RAM read, RAM_WAIT=0: AS_n low with RAMSEL_n low at edge 10 -> DTACK_n low after edge 10; AS_n high at edge 14 -> DTACK_n high after edge 14.
- ROM read, ROM_WAIT=2: ROMSEL_n low at edge 20 -> DTACK_n low after edge 22. Change ROMSEL_n to DUASEL_n at edge 21 -> timing unchanged.
- Unmapped access, BERR_TIMEOUT=64: AS_n low at edge 100, no selects -> BERR_n low after edge 163 and BERR_CNT=1. AS_n high -> BERR_n high next edge.
- Autovector: VPA_n low with AS_n at edge 30 -> DTACK_n and BERR_n stay high for the whole cycle; BUSY=1 until AS_n high.
- Abort and reset: EXP access (EXP_WAIT=3) with AS_n rising at edge k+1 -> no DTACK, IDLE. RST in WAIT or BERR -> all outputs at reset values next edge and BERR_CNT=0.
- Saturation: 260 consecutive unmapped cycles -> BERR_CNT=255.

Source files
------------

// File: rtl/simple008_pkg.sv
// Shared types for the Simple008 glue logic: bus-cycle FSM states, decoded
// regions and counter widths.
package simple008_pkg;

  localparam int WAIT_W = 4;
  localparam int TCNT_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PEND = 3'd1,
    WAIT = 3'd2,
    ACK  = 3'd3,
    VPA  = 3'd4,
    BERR = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    RG_ROM = 2'd0,
    RG_RAM = 2'd1,
    RG_DUA = 2'd2,
    RG_EXP = 2'd3
  } region_t;

  typedef struct packed {
    state_t              state;
    region_t             region;
    logic [WAIT_W-1:0]   wcnt;
    logic [TCNT_W-1:0]   tcnt;
  } dbg_t;

endpackage

// File: rtl/bus_cycle_ctrl.sv
// 68008 bus-cycle controller: per-region wait states ahead of DTACK_n and a
// watchdog that raises BERR_n on strobes nobody decodes.
module bus_cycle_ctrl
  import simple008_pkg::*;
#(
  parameter int ROM_WAIT     = 2,
  parameter int RAM_WAIT     = 0,
  parameter int DUA_WAIT     = 1,
  parameter int EXP_WAIT     = 3,
  parameter int BERR_TIMEOUT = 64
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       AS_n,
  input  logic       ROMSEL_n,
  input  logic       RAMSEL_n,
  input  logic       DUASEL_n,
  input  logic       EXPSEL_n,
  input  logic       DUAIACK_n,
  input  logic       VPA_n,
  output logic       DTACK_n,
  output logic       BERR_n,
  output logic       BUSY,
  output logic [7:0] BERR_CNT,
  output dbg_t       o_dbg
);

  // Handshake: the CPU opens a cycle by holding AS_n low; exactly one of
  // DTACK_n / BERR_n (or neither, for an autovector) goes low and stays low
  // until AS_n is sampled high, after which the FSM spends one edge in IDLE.
  if (ROM_WAIT >= BERR_TIMEOUT || RAM_WAIT >= BERR_TIMEOUT ||
      DUA_WAIT >= BERR_TIMEOUT || EXP_WAIT >= BERR_TIMEOUT ||
      BERR_TIMEOUT < 16 || BERR_TIMEOUT > 255) begin : g_bad_params
    $error("bus_cycle_ctrl: wait values must be below BERR_TIMEOUT (16..255)");
  end

  state_t              r_state, w_state_nx;
  region_t             r_region, w_region_nx;
  logic [WAIT_W-1:0]   r_wcnt, w_wcnt_nx;
  logic [TCNT_W-1:0]   r_tcnt, w_tcnt_nx;
  logic                r_dtack_n, w_dtack_n_nx;
  logic                r_berr_n, w_berr_n_nx;
  logic [7:0]          r_berr_cnt, w_berr_cnt_nx;

  logic                w_sel;
  region_t             w_region;
  logic [WAIT_W-1:0]   w_wait;

  always_comb begin
    w_sel    = 1'b1;
    w_region = RG_EXP;
    if (!ROMSEL_n)                     w_region = RG_ROM;
    else if (!RAMSEL_n)                w_region = RG_RAM;
    else if (!DUASEL_n || !DUAIACK_n)  w_region = RG_DUA;
    else if (!EXPSEL_n)                w_region = RG_EXP;
    else                               w_sel    = 1'b0;
    case (w_region)
      RG_ROM:  w_wait = WAIT_W'(ROM_WAIT);
      RG_RAM:  w_wait = WAIT_W'(RAM_WAIT);
      RG_DUA:  w_wait = WAIT_W'(DUA_WAIT);
      default: w_wait = WAIT_W'(EXP_WAIT);
    endcase
  end

  always_comb begin
    w_state_nx    = r_state;
    w_region_nx   = r_region;
    w_wcnt_nx     = r_wcnt;
    w_tcnt_nx     = r_tcnt;
    w_dtack_n_nx  = r_dtack_n;
    w_berr_n_nx   = r_berr_n;
    w_berr_cnt_nx = r_berr_cnt;
    case (r_state)
      IDLE, PEND: begin
        if (AS_n) begin
          w_state_nx = IDLE;
          w_tcnt_nx  = '0;
        end else if (w_sel) begin
          w_region_nx = w_region;
          if (w_wait == '0) begin
            w_state_nx   = ACK;
            w_dtack_n_nx = 1'b0;
          end else begin
            w_state_nx = WAIT;
            w_wcnt_nx  = w_wait;
          end
        end else if (!VPA_n) begin
          w_state_nx = VPA;
        end else if (r_state == IDLE) begin
          w_state_nx = PEND;
          w_tcnt_nx  = TCNT_W'(1);
        end else if (r_tcnt == TCNT_W'(BERR_TIMEOUT - 1)) begin
          w_state_nx  = BERR;
          w_berr_n_nx = 1'b0;
          if (r_berr_cnt != 8'hFF) w_berr_cnt_nx = r_berr_cnt + 8'd1;
        end else begin
          w_tcnt_nx = r_tcnt + TCNT_W'(1);
        end
      end
      WAIT: begin
        // Selects are deliberately not re-examined here: the region was latched.
        if (AS_n) begin
          w_state_nx = IDLE;
          w_wcnt_nx  = '0;
          w_tcnt_nx  = '0;
        end else if (r_wcnt == WAIT_W'(1)) begin
          w_state_nx   = ACK;
          w_wcnt_nx    = '0;
          w_dtack_n_nx = 1'b0;
        end else begin
          w_wcnt_nx = r_wcnt - WAIT_W'(1);
        end
      end
      ACK, VPA, BERR: begin
        if (AS_n) begin
          w_state_nx   = IDLE;
          w_tcnt_nx    = '0;
          w_dtack_n_nx = 1'b1;
          w_berr_n_nx  = 1'b1;
        end
      end
      default: begin
        w_state_nx   = IDLE;
        w_tcnt_nx    = '0;
        w_wcnt_nx    = '0;
        w_dtack_n_nx = 1'b1;
        w_berr_n_nx  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_region   <= RG_ROM;
      r_wcnt     <= '0;
      r_tcnt     <= '0;
      r_dtack_n  <= 1'b1;
      r_berr_n   <= 1'b1;
      r_berr_cnt <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_region   <= w_region_nx;
      r_wcnt     <= w_wcnt_nx;
      r_tcnt     <= w_tcnt_nx;
      r_dtack_n  <= w_dtack_n_nx;
      r_berr_n   <= w_berr_n_nx;
      r_berr_cnt <= w_berr_cnt_nx;
    end
  end

  assign DTACK_n  = r_dtack_n;
  assign BERR_n   = r_berr_n;
  assign BUSY     = (r_state != IDLE);
  assign BERR_CNT = r_berr_cnt;
  assign o_dbg    = '{state: r_state, region: r_region, wcnt: r_wcnt, tcnt: r_tcnt};

endmodule
